// File: rtl/decode_stage.sv
// ID stage: holds one {pc, inst} from fetch, decodes the MIPS subset, stalls on RAW
// hazards (no forwarding), resolves branches/jumps to fetch and hands a bundle to EXE.
module decode_stage (
    input  logic         clk,
    input  logic         resetn,
    input  logic         IF_over,
    input  logic [63:0]  IF_ID_bus,
    output logic         ID_allow_in,
    input  logic         EXE_allow_in,
    output logic         ID_over,
    output logic [147:0] ID_EXE_bus,
    output logic [32:0]  jbr_bus,
    output logic [4:0]   rf_raddr1,
    output logic [4:0]   rf_raddr2,
    input  logic [31:0]  rf_rdata1,
    input  logic [31:0]  rf_rdata2,
    input  logic [4:0]   EXE_wdest,
    input  logic [4:0]   MEM_wdest,
    input  logic [4:0]   WB_wdest,
    input  logic         cancel,
    output logic [31:0]  ID_pc,
    output logic [31:0]  ID_inst
);

    typedef enum logic [1:0] {EMPTY, DECODE, STALL, WAIT} state_t;

    state_t      state, state_next;
    logic [31:0] pc_p0, inst_p0;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm;
    logic        is_r;
    logic        is_addu, is_subu, is_slt, is_and, is_or, is_xor, is_sll, is_srl, is_jr;
    logic        is_addiu, is_ori, is_lui, is_lw, is_sw, is_beq, is_bne, is_j, is_jal;
    logic        use_rs, use_rt, hazard, handoff, latch;
    logic        rf_wen, branch_taken, jbr_taken;
    logic [4:0]  rf_wdest;
    logic [11:0] alu_op;
    logic [31:0] alu_src1, alu_src2, imm_sext, imm_zext, pc_plus4, br_target, jbr_target;

    function automatic logic raw_dep(input logic [4:0] src, input logic [4:0] e,
                                     input logic [4:0] m, input logic [4:0] w);
        return (src != 5'd0) && ((src == e) || (src == m) || (src == w));
    endfunction

    assign opcode = inst_p0[31:26];
    assign rs     = inst_p0[25:21];
    assign rt     = inst_p0[20:16];
    assign rd     = inst_p0[15:11];
    assign sa     = inst_p0[10:6];
    assign funct  = inst_p0[5:0];
    assign imm    = inst_p0[15:0];
    assign is_r   = (opcode == 6'b000000);

    assign is_addu  = is_r && (funct == 6'b100001);
    assign is_subu  = is_r && (funct == 6'b100011);
    assign is_slt   = is_r && (funct == 6'b101010);
    assign is_and   = is_r && (funct == 6'b100100);
    assign is_or    = is_r && (funct == 6'b100101);
    assign is_xor   = is_r && (funct == 6'b100110);
    assign is_sll   = is_r && (funct == 6'b000000);
    assign is_srl   = is_r && (funct == 6'b000010);
    assign is_jr    = is_r && (funct == 6'b001000);
    assign is_addiu = (opcode == 6'b001001);
    assign is_ori   = (opcode == 6'b001101);
    assign is_lui   = (opcode == 6'b001111);
    assign is_lw    = (opcode == 6'b100011);
    assign is_sw    = (opcode == 6'b101011);
    assign is_beq   = (opcode == 6'b000100);
    assign is_bne   = (opcode == 6'b000101);
    assign is_j     = (opcode == 6'b000010);
    assign is_jal   = (opcode == 6'b000011);

    // Only recognised instructions read sources; unsupported ones are NOPs and never stall
    assign use_rs = is_addu | is_subu | is_slt | is_and | is_or | is_xor | is_jr
                  | is_addiu | is_ori | is_lw | is_sw | is_beq | is_bne;
    assign use_rt = is_addu | is_subu | is_slt | is_and | is_or | is_xor | is_sll | is_srl
                  | is_jr | is_sw | is_beq | is_bne;
    assign hazard = (use_rs && raw_dep(rs, EXE_wdest, MEM_wdest, WB_wdest))
                  | (use_rt && raw_dep(rt, EXE_wdest, MEM_wdest, WB_wdest));

    assign ID_over     = ((state == DECODE) || (state == WAIT)) && !hazard && !cancel;
    assign handoff     = ID_over && EXE_allow_in;
    assign ID_allow_in = (state == EMPTY) || handoff;
    assign latch       = IF_over && ID_allow_in && !cancel;

    always_comb begin
        state_next = state;
        if (cancel)
            state_next = EMPTY;
        else if (latch)
            state_next = DECODE;
        else if (handoff)
            state_next = EMPTY;
        else begin
            case (state)
                DECODE:  state_next = hazard ? STALL : WAIT;
                STALL:   state_next = hazard ? STALL : DECODE;
                WAIT:    state_next = hazard ? STALL : WAIT;
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= EMPTY;
            pc_p0   <= 32'd0;
            inst_p0 <= 32'd0;
        end else begin
            state <= state_next;
            if (latch) begin
                pc_p0   <= IF_ID_bus[63:32];
                inst_p0 <= IF_ID_bus[31:0];
            end
        end
    end

    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'd0, imm};
    assign pc_plus4 = pc_p0 + 32'd4;

    assign alu_op = {is_addu | is_addiu | is_lw | is_sw | is_jal, is_subu, is_slt, is_and,
                     is_or | is_ori, is_xor, is_sll, is_srl, is_lui, 3'b000};

    assign alu_src1 = (is_sll || is_srl) ? {27'd0, sa} :
                      is_jal             ? pc_p0       : rf_rdata1;
    assign alu_src2 = (is_addiu || is_lw || is_sw) ? imm_sext :
                      (is_ori || is_lui)           ? imm_zext :
                      is_jal                       ? 32'd8    : rf_rdata2;

    assign rf_wen   = is_addu | is_subu | is_slt | is_and | is_or | is_xor | is_sll | is_srl
                    | is_addiu | is_ori | is_lui | is_lw | is_jal;
    assign rf_wdest = !rf_wen ? 5'd0  :
                      is_jal  ? 5'd31 :
                      is_r    ? rd    : rt;

    assign br_target  = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
    assign jbr_target = is_jr              ? rf_rdata1 :
                        (is_j || is_jal)   ? {pc_plus4[31:28], inst_p0[25:0], 2'b00} : br_target;

    assign branch_taken = is_j | is_jal | is_jr
                        | (is_beq && (rf_rdata1 == rf_rdata2))
                        | (is_bne && (rf_rdata1 != rf_rdata2));
    // Redirect fetch only on the handoff cycle so a stalled or flushed branch never leaks out
    assign jbr_taken = handoff && branch_taken;
    assign jbr_bus   = jbr_taken ? {1'b1, jbr_target} : 33'd0;

    assign ID_EXE_bus = {alu_op, is_lw, is_sw, alu_src1, alu_src2, rf_rdata2,
                         rf_wen, rf_wdest, pc_p0};

    assign rf_raddr1 = rs;
    assign rf_raddr2 = rt;
    assign ID_pc     = pc_p0;
    assign ID_inst   = inst_p0;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected EXE bundles are queued at issue and
// checked by an independent monitor at every handoff.
module tb_decode_stage;

    logic         clk, resetn, IF_over, EXE_allow_in, cancel;
    logic [63:0]  IF_ID_bus;
    logic         ID_allow_in, ID_over;
    logic [147:0] ID_EXE_bus;
    logic [32:0]  jbr_bus;
    logic [4:0]   rf_raddr1, rf_raddr2, EXE_wdest, MEM_wdest, WB_wdest;
    logic [31:0]  rf_rdata1, rf_rdata2, ID_pc, ID_inst;

    typedef struct packed {
        logic [147:0] bus;
        logic [32:0]  jbr;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    decode_stage dut (
        .clk(clk), .resetn(resetn), .IF_over(IF_over), .IF_ID_bus(IF_ID_bus),
        .ID_allow_in(ID_allow_in), .EXE_allow_in(EXE_allow_in), .ID_over(ID_over),
        .ID_EXE_bus(ID_EXE_bus), .jbr_bus(jbr_bus),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .EXE_wdest(EXE_wdest), .MEM_wdest(MEM_wdest), .WB_wdest(WB_wdest),
        .cancel(cancel), .ID_pc(ID_pc), .ID_inst(ID_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: r0 = 0, rN = 0x100 + N
    assign rf_rdata1 = (rf_raddr1 == 5'd0) ? 32'd0 : 32'h100 + {27'd0, rf_raddr1};
    assign rf_rdata2 = (rf_raddr2 == 5'd0) ? 32'd0 : 32'h100 + {27'd0, rf_raddr2};

    function automatic logic [147:0] pk(input logic [11:0] op, input logic ld, input logic st,
                                        input logic [31:0] s1, input logic [31:0] s2,
                                        input logic [31:0] sd, input logic wen,
                                        input logic [4:0] wd, input logic [31:0] pc);
        return {op, ld, st, s1, s2, sd, wen, wd, pc};
    endfunction

    task automatic chk(input string name, input logic [147:0] got, input logic [147:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            n_chk++;
            if (ID_over && EXE_allow_in) begin
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL handoff_unexpected: bus %h, no expected entry", ID_EXE_bus);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (ID_EXE_bus !== e.bus || jbr_bus !== e.jbr) begin
                        n_fail++;
                        $display("FAIL handoff pc=%h: got bus %h jbr %h, expected bus %h jbr %h",
                                 ID_pc, ID_EXE_bus, jbr_bus, e.bus, e.jbr);
                    end
                end
            end else if (jbr_bus !== 33'd0) begin
                n_fail++;
                $display("FAIL jbr_idle: got %h, expected 0", jbr_bus);
            end
        end
    end

    task automatic send(input logic [31:0] pc, input logic [31:0] inst, input logic push,
                        input logic [147:0] bus, input logic [32:0] jbr);
        exp_t e;
        logic acc;
        IF_ID_bus = {pc, inst};
        IF_over   = 1'b1;
        if (push) begin
            e.bus = bus;
            e.jbr = jbr;
            q.push_back(e);
        end
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            acc = ID_allow_in;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout pc=%h: got no accept, expected accept", pc);
        end
        IF_over = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_queue", 148'(q.size()), 148'd0);
    endtask

    localparam logic [11:0] OP_ADD = 12'h800, OP_SUB = 12'h400, OP_OR = 12'h080,
                            OP_SLL = 12'h020, OP_LUI = 12'h008;

    initial begin
        logic [147:0] bp_exp;
        resetn = 1'b1; IF_over = 1'b0; IF_ID_bus = 64'd0; EXE_allow_in = 1'b1; cancel = 1'b0;
        EXE_wdest = 5'd0; MEM_wdest = 5'd0; WB_wdest = 5'd0;
        #1 resetn = 1'b0;
        #2;
        chk("rst_allow_in", 148'(ID_allow_in), 148'd1);
        chk("rst_over", 148'(ID_over), 148'd0);
        chk("rst_jbr", 148'(jbr_bus), 148'd0);
        chk("rst_pc", 148'(ID_pc), 148'd0);
        chk("rst_inst", 148'(ID_inst), 148'd0);
        @(posedge clk); @(posedge clk); #1 resetn = 1'b1;

        // Back-to-back stream with EXE always ready
        send(32'h34, 32'h24020005, 1'b1, pk(OP_ADD, 0, 0, 32'h0, 32'h5, 32'h102, 1, 5'd2, 32'h34), 33'd0);
        chk("b2b_over", 148'(ID_over), 148'd1);
        chk("b2b_pc", 148'(ID_pc), 148'h34);
        send(32'h38, 32'h34238001, 1'b1, pk(OP_OR, 0, 0, 32'h101, 32'h8001, 32'h103, 1, 5'd3, 32'h38), 33'd0);
        chk("b2b_allow_in", 148'(ID_allow_in), 148'd1);
        send(32'h3C, 32'h8C24FFFC, 1'b1, pk(OP_ADD, 1, 0, 32'h101, 32'hFFFFFFFC, 32'h104, 1, 5'd4, 32'h3C), 33'd0);
        send(32'h40, 32'hAC250008, 1'b1, pk(OP_ADD, 0, 1, 32'h101, 32'h8, 32'h105, 0, 5'd0, 32'h40), 33'd0);
        drain();

        // RAW hazard on EXE, held for 3 cycles
        EXE_wdest = 5'd2;
        send(32'h44, 32'h00421821, 1'b1, pk(OP_ADD, 0, 0, 32'h102, 32'h102, 32'h102, 1, 5'd3, 32'h44), 33'd0);
        chk("raw_over_decode", 148'(ID_over), 148'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("raw_over_stall", 148'(ID_over), 148'd0);
            chk("raw_allow_stall", 148'(ID_allow_in), 148'd0);
        end
        EXE_wdest = 5'd0;
        #1 chk("raw_over_clear_cycle", 148'(ID_over), 148'd0);
        @(posedge clk); #1;
        chk("raw_over_after", 148'(ID_over), 148'd1);
        drain();

        // MEM hazard on rs then WB hazard on rt
        MEM_wdest = 5'd4;
        send(32'h48, 32'h00853023, 1'b1, pk(OP_SUB, 0, 0, 32'h104, 32'h105, 32'h105, 1, 5'd6, 32'h48), 33'd0);
        chk("mem_haz_over", 148'(ID_over), 148'd0);
        MEM_wdest = 5'd0; WB_wdest = 5'd5;
        @(posedge clk); #1;
        chk("wb_haz_over", 148'(ID_over), 148'd0);
        WB_wdest = 5'd0;
        @(posedge clk); #1;
        chk("haz_clear_over", 148'(ID_over), 148'd1);
        drain();

        // Branches, jumps, shifts, LUI and an unsupported opcode
        send(32'h40, 32'h10210004, 1'b1, pk(12'h0, 0, 0, 32'h101, 32'h101, 32'h101, 0, 5'd0, 32'h40), {1'b1, 32'h54});
        @(posedge clk); #1;
        chk("beq_one_cycle", 148'(jbr_bus), 148'd0);
        send(32'h50, 32'h10220004, 1'b1, pk(12'h0, 0, 0, 32'h101, 32'h102, 32'h102, 0, 5'd0, 32'h50), 33'd0);
        send(32'h60, 32'h1422FFFF, 1'b1, pk(12'h0, 0, 0, 32'h101, 32'h102, 32'h102, 0, 5'd0, 32'h60), {1'b1, 32'h60});
        send(32'h38, 32'h0C000010, 1'b1, pk(OP_ADD, 0, 0, 32'h38, 32'h8, 32'h0, 1, 5'd31, 32'h38), {1'b1, 32'h40});
        send(32'h70, 32'h00E00008, 1'b1, pk(12'h0, 0, 0, 32'h107, 32'h0, 32'h0, 0, 5'd0, 32'h70), {1'b1, 32'h107});
        send(32'h74, 32'h000940C0, 1'b1, pk(OP_SLL, 0, 0, 32'h3, 32'h109, 32'h109, 1, 5'd8, 32'h74), 33'd0);
        send(32'h78, 32'h3C0A1234, 1'b1, pk(OP_LUI, 0, 0, 32'h0, 32'h1234, 32'h10A, 1, 5'd10, 32'h78), 33'd0);
        send(32'h7C, 32'hFC221234, 1'b1, pk(12'h0, 0, 0, 32'h101, 32'h102, 32'h102, 0, 5'd0, 32'h7C), 33'd0);
        drain();

        // Backpressure: EXE not ready for 4 cycles
        EXE_allow_in = 1'b0;
        bp_exp = pk(OP_ADD, 0, 0, 32'h102, 32'h102, 32'h102, 1, 5'd3, 32'h80);
        send(32'h80, 32'h00421821, 1'b1, bp_exp, 33'd0);
        for (int k = 0; k < 4; k++) begin
            chk("bp_bus_stable", ID_EXE_bus, bp_exp);
            chk("bp_allow_in", 148'(ID_allow_in), 148'd0);
            chk("bp_over", 148'(ID_over), 148'd1);
            @(posedge clk); #1;
        end
        EXE_allow_in = 1'b1;
        drain();

        // Cancel a taken J sitting in WAIT, then cancel against a simultaneous latch
        EXE_allow_in = 1'b0;
        send(32'h90, 32'h08000020, 1'b0, 148'd0, 33'd0);
        @(posedge clk); #1;
        chk("wait_over", 148'(ID_over), 148'd1);
        cancel = 1'b1; EXE_allow_in = 1'b1;
        #1;
        chk("cancel_jbr", 148'(jbr_bus), 148'd0);
        chk("cancel_over", 148'(ID_over), 148'd0);
        @(posedge clk); #1;
        chk("cancel_empty_allow", 148'(ID_allow_in), 148'd1);
        IF_ID_bus = {32'hA0, 32'h24020005}; IF_over = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0; IF_over = 1'b0;
        chk("cancel_blocks_latch", 148'(ID_over), 148'd0);

        // Asynchronous reset while stalled
        EXE_wdest = 5'd2;
        send(32'hA0, 32'h00421821, 1'b0, 148'd0, 33'd0);
        @(posedge clk); #1;
        chk("stall_pc", 148'(ID_pc), 148'hA0);
        #2 resetn = 1'b0;
        #1;
        chk("arst_pc", 148'(ID_pc), 148'd0);
        chk("arst_inst", 148'(ID_inst), 148'd0);
        chk("arst_over", 148'(ID_over), 148'd0);
        chk("arst_allow", 148'(ID_allow_in), 148'd1);
        @(posedge clk); #1;
        resetn = 1'b1; EXE_wdest = 5'd0;
        chk("post_rst_allow", 148'(ID_allow_in), 148'd1);
        @(posedge clk); #1;
        chk("post_rst_over", 148'(ID_over), 148'd0);
        chk("final_queue", 148'(q.size()), 148'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Second stage (ID) of the five-stage CPU.
- Latches the 64-bit {pc, inst} bundle produced by the fetch stage and decodes a fixed MIPS subset.
- Reads the register file, stalls on register read-after-write hazards, and resolves branches/jumps back to fetch via a 33-bit {taken, target} bus.
- Hands a packed control/operand bundle to the execute stage under a valid/over/allow_in handshake.

Parameters:
- none: ISA subset and bus widths are fixed by this spec.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous reset, active-low
- IF_over  in  1  fetch stage holds a completed instruction
- IF_ID_bus  in  64  {pc[31:0], inst[31:0]} from fetch
- ID_allow_in  out  1  ID can accept a new instruction this cycle
- EXE_allow_in  in  1  execute stage accepts this cycle
- ID_over  out  1  ID instruction decoded, hazard-free, ready to hand off
- ID_EXE_bus  out  148  {alu_op[11:0], is_load, is_store, alu_src1[31:0], alu_src2[31:0], store_data[31:0], rf_wen, rf_wdest[4:0], pc[31:0]}
- jbr_bus  out  33  {jbr_taken, jbr_target[31:0]} to fetch
- rf_raddr1, rf_raddr2  out  5 each  register file read addresses (rs, rt)
- rf_rdata1, rf_rdata2  in  32 each  combinational read data
- EXE_wdest, MEM_wdest, WB_wdest  in  5 each  destination register of the in-flight instruction in that stage; 0 = none
- cancel  in  1  exception flush
- ID_pc, ID_inst  out  32 each  display of the held pc and instruction

Behaviour:
- Reset (async, resetn=0): state=EMPTY, ID_valid=0, held pc/inst=0, ID_over=0, jbr_bus=0, ID_allow_in=1.
- Input register:
  - ID_allow_in = (state==EMPTY) | (ID_over & EXE_allow_in).
  - On a posedge with IF_over & ID_allow_in, latch IF_ID_bus and go to DECODE.
  - If the held instruction leaves with no new input, go to EMPTY.
- States:
  - EMPTY: no instruction held.
  - DECODE: instruction held; leaves to STALL when a hazard is present.
  - STALL: hazard present; returns to DECODE when the hazard clears.
  - WAIT: decoded but EXE_allow_in=0.
  - ID_over=1 in DECODE/WAIT when no hazard. Handoff occurs when ID_over & EXE_allow_in.
- Hazard:
  - Source rs is used by all ops except J/JAL/LUI/SLL/SRL; rt is used by R-type, SW, BEQ, BNE.
  - A hazard exists when a used source is nonzero and equals EXE_wdest, MEM_wdest or WB_wdest.
  - No forwarding. Register 0 never causes a hazard.
- Decoded subset:
  - R-type: ADDU, SUBU, SLT, AND, OR, XOR, SLL, SRL, JR.
  - I-type: ADDIU, ORI, LUI, LW, SW, BEQ, BNE.
  - Jumps: J, JAL.
- Unsupported opcodes decode as NOP: rf_wen=0, alu_op=0, no branch.
- alu_op is one-hot: add, sub, slt, and, or, xor, sll, srl, lui, plus 3 spare bits =0.
- Immediate extension: ADDIU/LW/SW/BEQ/BNE sign-extend; ORI zero-extends. SLL/SRL take sa from inst[10:6] in alu_src1.
- Destinations:
  - rf_wdest = rd for R-type (0 for JR); rt for I-type writes; 31 for JAL.
  - JAL: alu_src1=pc, alu_src2=8, op add.
- Branch targets:
  - BEQ/BNE: pc+4+(sext(imm)<<2).
  - J/JAL: {pc_plus4[31:28], inst[25:0], 2'b00}.
  - JR: rf_rdata1.
- jbr_bus:
  - jbr_taken=1 for exactly the handoff cycle of a taken branch/jump; target is held valid in the same cycle.
  - Otherwise jbr_bus=0.
  - BEQ/BNE compare rf_rdata1 vs rf_rdata2 and are only evaluated hazard-free.
- cancel: on the next posedge, state→EMPTY, ID_valid=0, and no jbr_taken that cycle. cancel overrides a simultaneous latch.
- Simultaneous handoff and latch: the new instruction replaces the old in the same edge, with no bubble.
- Reset asserted mid-stall: everything clears immediately and asynchronously.

Test Plan:
- Reset mid-operation: pulse resetn=0 while in STALL → outputs 0 immediately, ID_allow_in=1 after release.
- Back-to-back handoff: ADDIU r2,r0,5 (0x24020005, pc 0x34) with EXE_allow_in=1 → ID_over next cycle; bus alu_src2=5, rf_wdest=2, add one-hot; ID_allow_in stays 1 across consecutive instructions.
- RAW stall: ADDU r3,r2,r2 with EXE_wdest=2 → ID_over=0 and STALL held. Same instruction with EXE_wdest=2 driven 0 after 3 cycles → ID_over rises the cycle after the hazard clears; single handoff.
- Branch: BEQ r1,r1,+4 at pc 0x40 with rdata equal → jbr_bus={1,0x54} for exactly one cycle. With rdata unequal → jbr_taken=0.
- JAL 0x0000010 at pc 0x38 → target 0x40, rf_wdest=31, alu_src1=0x38, alu_src2=8.
- Flush and backpressure:
  - cancel=1 while in WAIT with a taken J → no jbr_taken, state EMPTY.
  - EXE_allow_in=0 for 4 cycles → ID_EXE_bus stable, ID_allow_in=0.
